npc_unit: RTL and testbench

Parametrised fetch-address unit: owns the architectural PC register and computes the next fetch address each cycle. It covers sequential, conditional branch, j/jal, jr/jalr, exception-vector entry and eret return, with stall handling and delay-slot tracking. It sits in the F stage. It takes control-transfer requests from D, and exception/eret requests from M/CP0. It drives the instruction-memory address and the fetch-fault flags to the F/D pipeline register.

---
 rtl/npc_unit_if.sv | 54 +++++
 rtl/npc_unit.sv | 114 +++++++++++
 tb/tb_npc_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/npc_unit_if.sv
// npc_unit_if: groups the fetch-address unit's request and result signals.
//
// Requester side (D stage, M stage, CP0) drives:
//   stall       hazard stall, holds pc and D-sourced redirects
//   npc_op      D-stage control op: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr
//   br_taken    branch comparator result, meaningful when npc_op = 1
//   d_pc_plus4  PC+4 of the instruction in D
//   instr_idx   instr[25:0] of the instruction in D
//   rs_val      forwarded GPR[rs] for jr/jalr
//   exc_req     exception/interrupt entry pulse
//   eret_req    eret request
//   epc         eret return address
// Fetch-address unit drives:
//   pc, pc_plus4, pc_plus8  registered fetch address and its link offsets
//   f_adel      fetch fault (misaligned or outside legal instruction memory)
//   f_bd        instruction at pc sits in a delay slot
//   redirect    next pc is not pc+4 (combinational)
//
// Modports: master = requester side, slave = fetch-address unit.

interface npc_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              stall;
  logic [1:0]        npc_op;
  logic              br_taken;
  logic [ADDR_W-1:0] d_pc_plus4;
  logic [25:0]       instr_idx;
  logic [ADDR_W-1:0] rs_val;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_plus8;
  logic              f_adel;
  logic              f_bd;
  logic              redirect;

  modport master (
    output stall, npc_op, br_taken, d_pc_plus4, instr_idx, rs_val,
           exc_req, eret_req, epc,
    input  pc, pc_plus4, pc_plus8, f_adel, f_bd, redirect
  );

  modport slave (
    input  stall, npc_op, br_taken, d_pc_plus4, instr_idx, rs_val,
           exc_req, eret_req, epc,
    output pc, pc_plus4, pc_plus8, f_adel, f_bd, redirect
  );

endinterface

// File: rtl/npc_unit.sv
// npc_unit: F-stage fetch-address unit. Owns the architectural PC and picks the
// next fetch address each cycle from sequential, branch, j/jal, jr/jalr,
// exception-vector entry and eret return, with stall hold and delay-slot
// tracking.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset, forces pc to RESET_PC
//   bus_io  npc_unit_if slave modport (requests in, pc/fault/delay-slot out)
//
// next_pc priority, highest first: exc_req, eret_req, stall (hold),
// jr/jalr, j/jal, taken branch, pc+4.

module npc_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] IMEM_HI  = 32'h0000_6ffc
) (
  input  logic       clk,
  input  logic       reset,
  npc_unit_if.slave  bus_io
);

  typedef enum logic [1:0] {
    OpSeq    = 2'd0,
    OpBranch = 2'd1,
    OpJump   = 2'd2,
    OpJr     = 2'd3
  } npc_op_e;

  localparam logic [ADDR_W-1:0] Four  = {{(ADDR_W-4){1'b0}}, 4'd4};
  localparam logic [ADDR_W-1:0] Eight = {{(ADDR_W-4){1'b0}}, 4'd8};

  npc_op_e           op;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic [ADDR_W-1:0] pc_plus8_q;
  logic              f_bd_q, f_bd_d;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic              d_take;

  assign op = npc_op_e'(bus_io.npc_op);

  // All adds wrap modulo 2^ADDR_W; overflow is not flagged.
  assign seq_pc    = pc_q + Four;
  assign br_off    = {{(ADDR_W-18){bus_io.instr_idx[15]}}, bus_io.instr_idx[15:0], 2'b00};
  assign br_target = bus_io.d_pc_plus4 + br_off;

  // j/jal keeps the upper region bits of the delay-slot address.
  if (ADDR_W > 28) begin : g_j_region
    assign j_target = {bus_io.d_pc_plus4[ADDR_W-1:28], bus_io.instr_idx, 2'b00};
  end else begin : g_j_flat
    assign j_target = {bus_io.instr_idx, 2'b00};
  end

  // Requests that actually leave the pc+4 path if accepted from D.
  assign d_take = (op == OpJump) || (op == OpJr) || ((op == OpBranch) && bus_io.br_taken);

  always_comb begin
    pc_d   = seq_pc;
    f_bd_d = f_bd_q;
    if (bus_io.exc_req) begin
      // exc_req wins over a simultaneous eret_req, which is dropped.
      pc_d   = EXC_VEC;
      f_bd_d = 1'b0;
    end else if (bus_io.eret_req) begin
      pc_d   = bus_io.epc;
      f_bd_d = 1'b0;
    end else if (bus_io.stall) begin
      // D re-presents any redirect once the stall drops, so nothing is latched.
      pc_d   = pc_q;
      f_bd_d = f_bd_q;
    end else begin
      // The next fetch is a delay slot for any control op, taken or not.
      f_bd_d = (op != OpSeq);
      unique case (op)
        OpSeq:    pc_d = seq_pc;
        OpBranch: pc_d = bus_io.br_taken ? br_target : seq_pc;
        OpJump:   pc_d = j_target;
        OpJr:     pc_d = bus_io.rs_val;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + Four;
      pc_plus8_q <= RESET_PC + Eight;
      f_bd_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_d + Four;
      pc_plus8_q <= pc_d + Eight;
      f_bd_q     <= f_bd_d;
    end
  end

  assign bus_io.pc       = pc_q;
  assign bus_io.pc_plus4 = pc_plus4_q;
  assign bus_io.pc_plus8 = pc_plus8_q;
  assign bus_io.f_bd     = f_bd_q;

  // The unit keeps fetching on a fault; M/CP0 turns it into exc_req later.
  assign bus_io.f_adel = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

  assign bus_io.redirect = bus_io.exc_req || bus_io.eret_req || (!bus_io.stall && d_take);

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed, table-driven bench for npc_unit plus hand-written
// sequences for reset behaviour.

module tb_npc_unit;

  logic clk;
  logic reset;

  npc_unit_if #(.ADDR_W(32)) bus ();

  npc_unit dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  op;
    logic        br;
    logic [31:0] dpc4;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        e_redir;
    logic [31:0] e_pc;
    logic        e_bd;
    logic        e_adel;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic stall, input logic [1:0] op, input logic br,
                              input logic [31:0] dpc4, input logic [25:0] idx,
                              input logic [31:0] rs, input logic exc, input logic eret,
                              input logic [31:0] epc, input logic e_redir,
                              input logic [31:0] e_pc, input logic e_bd, input logic e_adel);
    vec_t v;
    v.stall = stall; v.op = op; v.br = br; v.dpc4 = dpc4; v.idx = idx; v.rs = rs;
    v.exc = exc; v.eret = eret; v.epc = epc; v.e_redir = e_redir; v.e_pc = e_pc;
    v.e_bd = e_bd; v.e_adel = e_adel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_bd,
                           input logic e_adel);
    chk({tag, " pc"}, bus.pc, e_pc);
    chk({tag, " pc_plus4"}, bus.pc_plus4, e_pc + 32'd4);
    chk({tag, " pc_plus8"}, bus.pc_plus8, e_pc + 32'd8);
    chk({tag, " f_bd"}, {31'd0, bus.f_bd}, {31'd0, e_bd});
    chk({tag, " f_adel"}, {31'd0, bus.f_adel}, {31'd0, e_adel});
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.npc_op = 2'd0; bus.br_taken = 1'b0; bus.d_pc_plus4 = '0;
    bus.instr_idx = '0; bus.rs_val = '0; bus.exc_req = 1'b0; bus.eret_req = 1'b0;
    bus.epc = '0;
  endtask

  task automatic apply(input vec_t v, input int i);
    bus.stall = v.stall; bus.npc_op = v.op; bus.br_taken = v.br; bus.d_pc_plus4 = v.dpc4;
    bus.instr_idx = v.idx; bus.rs_val = v.rs; bus.exc_req = v.exc; bus.eret_req = v.eret;
    bus.epc = v.epc;
    #1;
    chk($sformatf("vec%0d redirect", i), {31'd0, bus.redirect}, {31'd0, v.e_redir});
    @(posedge clk);
    #1;
    chk_state($sformatf("vec%0d", i), v.e_pc, v.e_bd, v.e_adel);
  endtask

  initial begin
    // stall op br dpc4 idx rs exc eret epc | redir pc bd adel
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300c, 0, 0));
    // taken backward branch, then seq clears f_bd, then not-taken branch
    vecs.push_back(mk(0, 1, 1, 32'h3008, 26'h000fffe, 0, 0, 0, 0, 1, 32'h3000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h3008, 26'h000fffe, 0, 0, 0, 0, 0, 32'h3008, 1, 0));
    // j, jr, seq, misaligned jr, seq from misaligned pc
    vecs.push_back(mk(0, 2, 0, 32'h3010, 26'h0000c40, 0, 0, 0, 0, 1, 32'h3100, 1, 0));
    vecs.push_back(mk(0, 3, 0, 0, 0, 32'h3ffc, 0, 0, 0, 1, 32'h3ffc, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4000, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0, 0, 32'h3001, 0, 0, 0, 1, 32'h3001, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3005, 0, 1));
    vecs.push_back(mk(0, 2, 0, 32'h3010, 26'h0000c40, 0, 0, 0, 0, 1, 32'h3100, 1, 0));
    // three stalled cycles with a pending j: pc and f_bd hold
    vecs.push_back(mk(1, 2, 0, 32'h3010, 26'h0000c80, 0, 0, 0, 0, 0, 32'h3100, 1, 0));
    vecs.push_back(mk(1, 2, 0, 32'h3010, 26'h0000c80, 0, 0, 0, 0, 0, 32'h3100, 1, 0));
    vecs.push_back(mk(1, 2, 0, 32'h3010, 26'h0000c80, 0, 0, 0, 0, 0, 32'h3100, 1, 0));
    // exception overrides stall; exc beats eret; then eret alone
    vecs.push_back(mk(1, 2, 0, 32'h3010, 26'h0000c80, 0, 1, 0, 0, 1, 32'h4180, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h3020, 1, 32'h4180, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h3020, 1, 32'h3020, 0, 0));
    // eret clears a set f_bd; stall holds f_bd=0
    vecs.push_back(mk(0, 3, 0, 0, 0, 32'h3100, 0, 0, 0, 1, 32'h3100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h3040, 1, 32'h3040, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3040, 0, 0));
    // forward branch
    vecs.push_back(mk(0, 1, 1, 32'h3044, 26'h0000010, 0, 0, 0, 0, 1, 32'h3084, 1, 0));
    // wrap-around: jr to top of space, seq wraps to 0
    vecs.push_back(mk(0, 3, 0, 0, 0, 32'hfffffffc, 0, 0, 0, 1, 32'hfffffffc, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 1));
    // j keeps upper four bits of d_pc_plus4
    vecs.push_back(mk(0, 2, 0, 32'ha0003010, 26'h0000c40, 0, 0, 0, 0, 1, 32'ha0003100, 1, 1));
    vecs.push_back(mk(0, 3, 0, 0, 0, 32'h3100, 0, 0, 0, 1, 32'h3100, 1, 0));

    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk_state("reset", 32'h3000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_state("reset_held", 32'h3000, 1'b0, 1'b0);
    #2 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset between edges while pc = 0x3100.
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk_state("async_reset", 32'h3000, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post_reset", 32'h3004, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
